// File: rtl/sd_arb_pkg.sv
// Shared types and helpers for the SD drive arbiter.
// Timeout watchdog is enabled by defining SD_TIMEOUT_EN.
package sd_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    ISSUE,
    XFER,
    DONE,
    FAIL
  } state_t;

  localparam int SECT_SHIFT = 9;

  // First requester after ptr, wrapping modulo n.
  function automatic logic [1:0] rr_pick(
    input logic [3:0] req,
    input logic [1:0] ptr,
    input int         n
  );
    logic [1:0] g;
    logic [1:0] idx;
    g = ptr;
    for (int k = 4; k >= 1; k--) begin
      idx = 2'((int'(ptr) + k) % n);
      if (k <= n && req[idx]) g = idx;
    end
    return g;
  endfunction

endpackage

// File: rtl/sd_drive_status.sv
// Per-drive mount, write-protect and size state.
// Produces the legality verdict used when a grant is checked.
module sd_drive_status
  import sd_arb_pkg::*;
#(
  parameter int LBA_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mount,
  input  logic             readonly,
  input  logic [63:0]      size,
  input  logic             clr,
  input  logic [LBA_W-1:0] lba,
  input  logic             wr,
  output logic             legal
);

  logic        mounted;
  logic        ro;
  logic [31:0] nsect;

  always_ff @(posedge clk) begin
    if (reset) begin
      mounted <= 1'b0;
      ro      <= 1'b0;
      nsect   <= '0;
    end else if (mount) begin
      mounted <= size != 64'd0;
      ro      <= readonly;
      nsect   <= size[SECT_SHIFT +: 32];
    end else if (clr) begin
      mounted <= 1'b0;
    end
  end

  assign legal = mounted
              && (64'(lba) < 64'(nsect))
              && !(wr && ro);

endmodule

// File: rtl/sd_drive_arbiter.sv
// Round-robin sequencer of drive sector requests onto hps_io.
// Optional SD_TIMEOUT_EN adds a watchdog on ISSUE/XFER.
module sd_drive_arbiter
  import sd_arb_pkg::*;
#(
  parameter int NDRV    = 2,
  parameter int LBA_W   = 32,
  parameter int TMO_CYC = 42000000
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  input  logic [NDRV-1:0]       req_rd,
  input  logic [NDRV-1:0]       req_wr,
  input  logic [NDRV*LBA_W-1:0] req_lba,
  output logic [NDRV-1:0]       req_done,
  output logic [NDRV-1:0]       req_err,
  input  logic [NDRV-1:0]       img_mounted,
  input  logic                  img_readonly,
  input  logic [63:0]           img_size,
  output logic [NDRV*LBA_W-1:0] sd_lba,
  output logic [NDRV-1:0]       sd_rd,
  output logic [NDRV-1:0]       sd_wr,
  input  logic [NDRV-1:0]       sd_ack,
  output logic [1:0]            buf_sel,
  output logic                  busy
);

  state_t           state;
  logic [1:0]       gnt;
  logic [1:0]       ptr;
  logic             wr_q;
  logic             hold;
  logic [LBA_W-1:0] lba_q;
  logic [LBA_W-1:0] lba_out [NDRV];

  logic [NDRV-1:0]  avail;
  logic [NDRV-1:0]  gnt_oh;
  logic [NDRV-1:0]  legal;
  logic [NDRV-1:0]  clr;
  logic [1:0]       pick;
  logic             pick_wr;
  logic [LBA_W-1:0] pick_lba;
  logic             ack_g;
  logic             legal_g;
  logic             tmo_hit;

  // hold masks the just-served channel for its first IDLE cycle
  always_comb begin
    avail    = '0;
    gnt_oh   = '0;
    ack_g    = 1'b0;
    legal_g  = 1'b0;
    pick_wr  = 1'b0;
    pick_lba = '0;
    for (int i = 0; i < NDRV; i++) begin
      avail[i]  = (req_rd[i] | req_wr[i])
               && !(hold && gnt == 2'(i));
      gnt_oh[i] = gnt == 2'(i);
      if (gnt_oh[i]) begin
        ack_g   = sd_ack[i];
        legal_g = legal[i];
      end
    end
    pick = rr_pick(4'(avail), ptr, NDRV);
    for (int i = 0; i < NDRV; i++) begin
      if (pick == 2'(i)) begin
        pick_wr  = !req_rd[i] && req_wr[i];
        pick_lba = req_lba[i*LBA_W +: LBA_W];
      end
    end
  end

  assign clr  = tmo_hit ? gnt_oh : '0;
  assign busy = state != IDLE;

  for (genvar i = 0; i < NDRV; i++) begin : g_drv
    sd_drive_status #(.LBA_W(LBA_W)) u_stat (
      .clk      (clk_sys),
      .reset    (reset),
      .mount    (img_mounted[i]),
      .readonly (img_readonly),
      .size     (img_size),
      .clr      (clr[i]),
      .lba      (lba_q),
      .wr       (wr_q),
      .legal    (legal[i])
    );
    assign sd_lba[i*LBA_W +: LBA_W] = lba_out[i];
  end

`ifdef SD_TIMEOUT_EN
  localparam int CW = $clog2(TMO_CYC + 1);
  logic [CW-1:0] cnt;
  logic          waiting;

  assign waiting = state == ISSUE || state == XFER;
  assign tmo_hit = waiting && cnt == CW'(TMO_CYC - 1);

  always_ff @(posedge clk_sys) begin
    if (reset || !waiting || (state == ISSUE && ack_g))
      cnt <= '0;
    else
      cnt <= cnt + CW'(1);
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state    <= IDLE;
      gnt      <= '0;
      ptr      <= '0;
      wr_q     <= 1'b0;
      hold     <= 1'b0;
      lba_q    <= '0;
      buf_sel  <= '0;
      sd_rd    <= '0;
      sd_wr    <= '0;
      req_done <= '0;
      req_err  <= '0;
      for (int i = 0; i < NDRV; i++)
        lba_out[i] <= '0;
    end else begin
      req_done <= '0;
      req_err  <= '0;
      unique case (state)
        IDLE: begin
          hold <= 1'b0;
          if (|avail) begin
            gnt     <= pick;
            ptr     <= pick;
            buf_sel <= pick;
            wr_q    <= pick_wr;
            lba_q   <= pick_lba;
            state   <= CHECK;
          end
        end
        CHECK: begin
          if (legal_g) begin
            sd_rd <= wr_q ? '0 : gnt_oh;
            sd_wr <= wr_q ? gnt_oh : '0;
            for (int i = 0; i < NDRV; i++)
              if (gnt_oh[i]) lba_out[i] <= lba_q;
            state <= ISSUE;
          end else begin
            req_err <= gnt_oh;
            state   <= FAIL;
          end
        end
        ISSUE: begin
          if (ack_g) begin
            sd_rd <= '0;
            sd_wr <= '0;
            state <= XFER;
          end
        end
        XFER: begin
          if (!ack_g) begin
            req_done <= gnt_oh;
            state    <= DONE;
          end
        end
        DONE, FAIL: begin
          hold  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (tmo_hit) begin
        sd_rd    <= '0;
        sd_wr    <= '0;
        req_done <= '0;
        req_err  <= gnt_oh;
        state    <= FAIL;
      end
    end
  end

endmodule

// File: doc/sd_drive_arbiter.md
Name: sd_drive_arbiter

Overview:
- Sequences sector read/write requests from NDRV virtual floppy drive channels onto the per-drive sd_rd/sd_wr/sd_ack handshake of the HPS I/O block.
- Grants one request at a time, round-robin, and steers the shared sector buffer (buf_sel).
- Tracks mount state, size and write protection per drive; rejects illegal requests without touching the HPS.
- Sits between the FDC request logic inside the trs80 core and hps_io.

Parameters:
- NDRV, 2, number of drive channels (1..4).
- LBA_W, 32, sector address width.
- TMO_CYC, 42000000, watchdog limit in clk_sys cycles (used only with SD_TIMEOUT_EN).

Ports:
- clk_sys  in  1  system clock (42 MHz).
- reset  in  1  synchronous, active-high reset.
- req_rd  in  NDRV  per-channel read request level; held until done/err.
- req_wr  in  NDRV  per-channel write request level; held until done/err.
- req_lba  in  NDRV*LBA_W  per-channel sector address; channel i at [i*LBA_W +: LBA_W].
- req_done  out  NDRV  one-cycle success pulse per channel.
- req_err  out  NDRV  one-cycle failure pulse per channel.
- img_mounted  in  NDRV  per-drive mount strobe from hps_io.
- img_readonly  in  1  write-protect flag, valid with the img_mounted strobe.
- img_size  in  64  image size in bytes, valid with the img_mounted strobe.
- sd_lba  out  NDRV*LBA_W  per-drive LBA to hps_io.
- sd_rd  out  NDRV  per-drive read strobe to hps_io.
- sd_wr  out  NDRV  per-drive write strobe to hps_io.
- sd_ack  in  NDRV  per-drive acknowledge from hps_io.
- buf_sel  out  2  index of the granted drive, for the sector-buffer mux.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values: all outputs 0; all drives unmounted (mounted=0, ro=0, nsect=0); round-robin pointer = 0; state = IDLE.
- Mount tracking:
  - On img_mounted[i], latch mounted[i] = (img_size != 0), ro[i] = img_readonly, nsect[i] = img_size[40:9].
  - A strobe during an active transfer is latched immediately; the transfer in flight continues.
- Request legality:
  - A channel requests when req_rd | req_wr.
  - If both req_rd and req_wr are set, read wins.
- Arbitration:
  - In IDLE, scan channels starting at ptr+1 (mod NDRV) and grant the first requester.
  - On grant, latch gnt, op and lba; buf_sel = gnt; ptr = gnt.
  - Decision takes 1 cycle: grant is registered on the cycle after the request is seen.
- FSM states:
  - IDLE: no requester stays in IDLE. With a grant, go to CHECK.
  - CHECK (1 cycle): error if !mounted[gnt], or lba >= nsect[gnt], or (write && ro[gnt]). Error goes to FAIL; otherwise ISSUE.
  - ISSUE: drive sd_lba[gnt] = lba and assert sd_rd[gnt] or sd_wr[gnt]. Hold until sd_ack[gnt] = 1, then drop the strobe and go to XFER.
  - XFER: wait for sd_ack[gnt] = 0, then go to DONE.
  - DONE: req_done[gnt] = 1 for one cycle, then IDLE.
  - FAIL: req_err[gnt] = 1 for one cycle, then IDLE.
- Minimum latency from request to done is 4 cycles plus the HPS ack time.
- sd_lba[i] holds its last value when drive i is not granted; other channels' sd_lba are never disturbed.
- A requester must drop req_* in the cycle after done/err. The arbiter does not re-grant the same channel until it has been back in IDLE for one cycle.
- Request withdrawn mid-transfer: ignored, the transfer completes and done still pulses.
- ack already high in ISSUE (stale): treated as acknowledge.
- Reset mid-operation: strobes drop the next cycle, no done/err pulse, state returns to IDLE.
- NDRV = 1: the pointer is constant 0.

Optional Feature:
- Macro: SD_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in ISSUE and XFER and clears on every state change.
  - Reaching TMO_CYC forces FAIL: req_err pulses, strobes drop, mounted[gnt] is cleared.
- Undefined: no counter exists and ISSUE/XFER wait indefinitely.

Decomposition:
- Package sd_arb_pkg holds:
  - typedef state_t {IDLE, CHECK, ISSUE, XFER, DONE, FAIL};
  - SECT_SHIFT = 9;
  - function rr_pick(req, ptr) returning the next grant index.
- Sub-module sd_drive_status (one instance per drive) holds the mount/ro/nsect registers and produces the legality result for the CHECK state.

Test Plan:
- Mount drive 0 with size 0x16800 (180 sectors); req_rd[0], lba=5; hps acks 3 cycles later, holds ack 10 cycles → sd_rd[0]=1 until ack rises, sd_lba[0]=5, req_done[0] pulses once, busy returns to 0.
- req_rd[1] with drive 1 unmounted → req_err[1] one pulse; sd_rd and sd_wr stay 0 throughout.
- Drive 0 mounted readonly; req_wr[0] lba=0 → req_err[0]. The same request with lba=180 on a writable mount → req_err[0] (out of range); lba=179 → success.
- req_rd[0] and req_rd[1] asserted together from reset (ptr=0) → drive 1 granted first (buf_sel=1), drive 0 served after; alternation holds over 4 back-to-back rounds.
- reset asserted while in XFER → the next cycle has sd_rd=0, busy=0, no done/err pulse; a new request completes normally afterwards.
- SD_TIMEOUT_EN with TMO_CYC=100, ack never returned → req_err pulses 100 cycles after ISSUE is entered, mounted[0] is cleared, and the next request to drive 0 fails in CHECK.
